// File: rtl/pad_switch_pkg.sv
// Shared constants and types for the pad output switch controller.
package pad_switch_pkg;

  // Register byte offsets
  localparam logic [11:0] OFF_SEL    = 12'h000;
  localparam logic [11:0] OFF_IDLE   = 12'h004;
  localparam logic [11:0] OFF_GUARD  = 12'h008;
  localparam logic [11:0] OFF_STATUS = 12'h00C;
  localparam logic [11:0] OFF_ID     = 12'h010;

  localparam logic [31:0] ID_VALUE = 32'h5057_0001;

  // Pad source encoding
  typedef enum logic [1:0] {
    SRC_GPIO = 2'd0,
    SRC_ALT0 = 2'd1,
    SRC_ALT1 = 2'd2,
    SRC_ALT2 = 2'd3
  } src_e;

  // Per-pin switch state
  typedef enum logic {
    StActive = 1'b0,
    StGuard  = 1'b1
  } pin_state_e;

  // APB word address of a register byte offset
  function automatic logic [9:0] word_addr(input logic [11:0] off);
    return off[11:2];
  endfunction

endpackage

// File: rtl/pad_switch_channel.sv
// One pad: source-switch FSM, guard counter, current source and output mux.
module pad_switch_channel
  import pad_switch_pkg::*;
#(
  parameter int unsigned GuardW = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        sel_i,
  input  logic              idle_i,
  input  logic [GuardW-1:0] guard_i,
  input  logic [3:0]        src_i,    // indexed by source code
  output logic              pad_o,
  output logic              busy_o
);

  pin_state_e        state_q, state_d;
  logic [GuardW-1:0] cnt_q, cnt_d;
  logic [1:0]        cur_sel_q, cur_sel_d;

  // State, counter and current-source registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StActive;
      cnt_q     <= '0;
      cur_sel_q <= SRC_GPIO;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  // Next state: a source change either switches at once (zero guard) or
  // parks the pad at its idle level; the SEL value present at exit wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    unique case (state_q)
      StActive: begin
        if (sel_i != cur_sel_q) begin
          if (guard_i == '0) begin
            cur_sel_d = sel_i;
          end else begin
            state_d = StGuard;
            cnt_d   = guard_i;
          end
        end
      end
      StGuard: begin
        cnt_d = cnt_q - GuardW'(1);
        if (cnt_q == GuardW'(1)) begin
          cur_sel_d = sel_i;
          state_d   = StActive;
        end
      end
    endcase
  end

  // Pad drive: idle level while guarding, else the selected source
  always_comb begin
    busy_o = (state_q == StGuard);
    pad_o  = busy_o ? idle_i : src_i[cur_sel_q];
  end

endmodule

// File: rtl/pad_output_switch_ctrl.sv
// APB register file and read mux sharing output pads between GPIO and
// three alternate functions, with one guarded switch channel per pad.
module pad_output_switch_ctrl
  import pad_switch_pkg::*;
#(
  parameter int unsigned NUM_PINS  = 8,
  parameter int unsigned GUARD_W   = 4,
  parameter int unsigned GUARD_RST = 4
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [11:2]         PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  input  logic [NUM_PINS-1:0] gpio_out,
  input  logic [NUM_PINS-1:0] alt0_out,
  input  logic [NUM_PINS-1:0] alt1_out,
  input  logic [NUM_PINS-1:0] alt2_out,
  output logic [NUM_PINS-1:0] pad_out,
  output logic [NUM_PINS-1:0] pad_busy
);

  logic [2*NUM_PINS-1:0] sel_q;
  logic [NUM_PINS-1:0]   idle_q;
  logic [GUARD_W-1:0]    guard_q;
  logic                  wr_en;
  logic                  unused_wdata;

  assign wr_en        = PSEL & PENABLE & PWRITE;
  assign PREADY       = 1'b1;
  assign PSLVERR      = 1'b0;
  assign unused_wdata = ^PWDATA;

  // Software registers, written in the APB access phase
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sel_q   <= '0;
      idle_q  <= '0;
      guard_q <= GUARD_W'(GUARD_RST);
    end else if (wr_en) begin
      if (PADDR == word_addr(OFF_SEL))   sel_q   <= PWDATA[2*NUM_PINS-1:0];
      if (PADDR == word_addr(OFF_IDLE))  idle_q  <= PWDATA[NUM_PINS-1:0];
      if (PADDR == word_addr(OFF_GUARD)) guard_q <= PWDATA[GUARD_W-1:0];
    end
  end

  // Combinational read mux; zero when not selected or unmapped
  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      if (PADDR == word_addr(OFF_SEL))         PRDATA = 32'(sel_q);
      else if (PADDR == word_addr(OFF_IDLE))   PRDATA = 32'(idle_q);
      else if (PADDR == word_addr(OFF_GUARD))  PRDATA = 32'(guard_q);
      else if (PADDR == word_addr(OFF_STATUS)) PRDATA = 32'(pad_busy);
      else if (PADDR == word_addr(OFF_ID))     PRDATA = ID_VALUE;
    end
  end

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    pad_switch_channel #(
      .GuardW (GUARD_W)
    ) u_channel (
      .clk_i   (PCLK),
      .rst_ni  (PRESETn),
      .sel_i   (sel_q[2*i +: 2]),
      .idle_i  (idle_q[i]),
      .guard_i (guard_q),
      .src_i   ({alt2_out[i], alt1_out[i], alt0_out[i], gpio_out[i]}),
      .pad_o   (pad_out[i]),
      .busy_o  (pad_busy[i])
    );
  end

endmodule

// File: tb/tb_pad_output_switch_ctrl.sv
// Randomised bench for pad_output_switch_ctrl with a cycle-level pad model.
module tb_pad_output_switch_ctrl;

  localparam int NP = 8;
  localparam int GW = 4;
  localparam int GR = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [9:0]    PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic [NP-1:0] gpio = '0, a0 = '0, a1 = '0, a2 = '0;
  logic [NP-1:0] pad_out, pad_busy;

  pad_output_switch_ctrl #(
    .NUM_PINS  (NP),
    .GUARD_W   (GW),
    .GUARD_RST (GR)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .gpio_out (gpio),
    .alt0_out (a0),
    .alt1_out (a1),
    .alt2_out (a2),
    .pad_out  (pad_out),
    .pad_busy (pad_busy)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each pin: which source it currently passes, and how many idle cycles remain.
  int            m_sel[NP];
  logic [NP-1:0] m_idle;
  int            m_guard;
  int            m_cur[NP];
  int            m_left[NP];

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_sel[i] = 0; m_cur[i] = 0; m_left[i] = 0;
    end
    m_idle  = '0;
    m_guard = GR;
  endtask

  initial model_reset();

  function automatic logic [31:0] m_sel_word();
    logic [31:0] w = '0;
    for (int i = 0; i < NP; i++) w = w | (32'(m_sel[i]) << (2 * i));
    return w;
  endfunction

  function automatic logic [NP-1:0] m_busy();
    logic [NP-1:0] b;
    for (int i = 0; i < NP; i++) b[i] = (m_left[i] > 0);
    return b;
  endfunction

  function automatic logic [31:0] m_read(input logic [9:0] wa);
    case (wa)
      10'd0:   return m_sel_word();
      10'd1:   return 32'(m_idle);
      10'd2:   return 32'(m_guard);
      10'd3:   return 32'(m_busy());
      10'd4:   return 32'h5057_0001;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge PRESETn) model_reset();

  // Advance model one clock: pin behaviour uses register values from before the edge
  always @(posedge PCLK) begin
    if (!PRESETn) begin
      model_reset();
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (m_left[i] > 0) begin
          m_left[i]--;
          if (m_left[i] == 0) m_cur[i] = m_sel[i];
        end else if (m_sel[i] != m_cur[i]) begin
          if (m_guard == 0) m_cur[i] = m_sel[i];
          else m_left[i] = m_guard;
        end
      end
      if (PSEL && PENABLE && PWRITE) begin
        case (PADDR)
          10'd0: for (int i = 0; i < NP; i++) m_sel[i] = int'((PWDATA >> (2 * i)) & 32'h3);
          10'd1: m_idle = PWDATA[NP-1:0];
          10'd2: m_guard = int'(PWDATA[GW-1:0]);
          default: ;
        endcase
      end
    end
  end

  // Compare process: all outputs every cycle, mid-cycle
  always @(negedge PCLK) begin
    logic [NP-1:0] ep, eb;
    logic [31:0]   er;
    if (!PRESETn) begin
      ep = gpio; eb = '0; er = '0;
    end else begin
      eb = m_busy();
      for (int i = 0; i < NP; i++) begin
        if (eb[i]) ep[i] = m_idle[i];
        else case (m_cur[i])
          0: ep[i] = gpio[i];
          1: ep[i] = a0[i];
          2: ep[i] = a1[i];
          default: ep[i] = a2[i];
        endcase
      end
      er = PSEL ? m_read(PADDR) : 32'h0;
    end
    check("pad_out", 32'(pad_out), 32'(ep));
    check("pad_busy", 32'(pad_busy), 32'(eb));
    check("PRDATA", PRDATA, er);
    check("PREADY/PSLVERR", {30'h0, PREADY, PSLVERR}, 32'h2);
  end

  // Peripheral sources toggle randomly every cycle
  always @(posedge PCLK) begin
    #1;
    gpio = NP'($urandom); a0 = NP'($urandom); a1 = NP'($urandom); a2 = NP'($urandom);
  end

  // ---------------- APB driver (call just after a rising edge) ----------------
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    logic [11:0] aa = a;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = aa[11:2]; PWDATA = d;
    @(posedge PCLK); #1; PENABLE = 1;
    @(posedge PCLK); #1; PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [11:0] a, input int ncyc, output logic [31:0] v);
    logic [11:0] aa = a;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = aa[11:2];
    for (int k = 0; k < ncyc; k++) begin
      @(negedge PCLK); v = PRDATA;
      @(posedge PCLK); #1; PENABLE = 1;
    end
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge PCLK); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    int cnt, first;
    logic ok;

    idle_cycles(3);
    PRESETn = 1;
    idle_cycles(2);

    // Reset values and constant ID
    apb_read(12'h010, 1, v); check("ID", v, 32'h5057_0001);
    apb_read(12'h00C, 1, v); check("STATUS reset", v, 32'h0);
    apb_read(12'h008, 1, v); check("GUARD reset", v, 32'h4);
    idle_cycles(4);

    // Guard of 4 with idle-high on pin 2
    apb_write(12'h008, 32'd4);
    apb_write(12'h004, 32'h04);
    apb_write(12'h000, 32'h10);
    cnt = 0; first = -1; ok = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge PCLK);
      if (pad_busy[2]) begin
        cnt++;
        if (first < 0) first = k;
        if (pad_out[2] !== 1'b1) ok = 0;
      end
    end
    @(posedge PCLK); #1;
    check("pin2 guard length", 32'(cnt), 32'd4);
    check("pin2 guard start", 32'(first), 32'd1);
    check("pin2 idle level", 32'(ok), 32'd1);

    // Zero guard: pin 0 straight to alt2
    apb_write(12'h008, 32'd0);
    apb_write(12'h000, 32'h13);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      if (pad_busy != '0) cnt++;
      if (k == 1) check("pin0 alt2 next cycle", 32'(pad_out[0]), 32'(a2[0]));
    end
    @(posedge PCLK); #1;
    check("zero guard no busy", 32'(cnt), 32'd0);

    // Guard of 8; pin 3 retargeted mid-guard, exits on alt1
    apb_write(12'h008, 32'd8);
    apb_write(12'h000, 32'h53);
    idle_cycles(1);
    apb_write(12'h000, 32'h93);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge PCLK);
      if (pad_busy[3]) cnt++;
    end
    check("pin3 remaining guard", 32'(cnt), 32'd6);
    check("pin3 exits on alt1", 32'(pad_out[3]), 32'(a1[3]));
    @(posedge PCLK); #1;

    // Overlapping guards on pins 0 and 5
    apb_write(12'h008, 32'd3);
    apb_write(12'h000, 32'h91);
    apb_write(12'h000, 32'h891);
    apb_read(12'h00C, 2, v);
    check("STATUS overlap", v, 32'h21);
    idle_cycles(6);

    // Reset in the middle of a guard on pin 1 (two cycles left)
    apb_write(12'h008, 32'd4);
    apb_write(12'h000, 32'h895);
    for (int k = 0; k < 4; k++) @(negedge PCLK);
    check("pin1 busy before reset", 32'(pad_busy[1]), 32'd1);
    #1 PRESETn = 0;
    #1;
    check("busy in reset", 32'(pad_busy), 32'h0);
    check("pin1 gpio in reset", 32'(pad_out[1]), 32'(gpio[1]));
    @(posedge PCLK); #1; PRESETn = 1;
    apb_read(12'h000, 1, v); check("SEL after reset", v, 32'h0);

    // Random traffic
    for (int it = 0; it < 1500; it++) begin
      int r = int'($urandom_range(0, 19));
      logic [11:0] a;
      case (r)
        0, 1, 2, 3: apb_write(12'h000, $urandom);
        4, 5:       apb_write(12'h004, $urandom);
        6:          apb_write(12'h008, 32'($urandom_range(0, 5)));
        7:          apb_write(12'h008, $urandom);
        8, 9: begin
          a = 12'($urandom_range(0, 6) * 4);
          apb_write(a + 12'h00C, $urandom);
        end
        10, 11, 12, 13: begin
          a = 12'($urandom_range(0, 6) * 4);
          apb_read(a, int'($urandom_range(1, 3)), v);
        end
        14: begin
          a = 12'($urandom) & 12'hFFC;
          apb_read(a, 1, v);
        end
        15: begin
          if ($urandom_range(0, 9) == 0) begin
            @(negedge PCLK); #2 PRESETn = 0;
            @(posedge PCLK); #1 PRESETn = 1;
          end
        end
        default: idle_cycles(int'($urandom_range(1, 4)));
      endcase
    end
    idle_cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
